// File: rtl/link_arbiter.sv
// link_arbiter: round-robin arbiter sharing one 4-phase req/ack byte link
// among NUM_REQ requesters. A grant lasts up to BURST_LEN bytes, and an ack
// timeout aborts any byte the slave never answers.
module link_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                 clk_sig,
  input  logic                 rst_n,        // active-high asynchronous reset
  input  logic [NUM_REQ-1:0]   m_req,
  input  logic [8*NUM_REQ-1:0] m_data,
  output logic [NUM_REQ-1:0]   m_ack,
  output logic                 s_req,
  output logic [7:0]           s_data,
  input  logic                 s_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BCW   = $clog2(BURST_LEN + 1);
  localparam int unsigned TOW   = 8;
  localparam logic [NUM_REQ-1:0] GRANT_LSB = NUM_REQ'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GRANT    = 3'd1,
    WAIT_ACK = 3'd2,
    WAIT_LOW = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic [BCW-1:0]   beat_cnt;
  logic [TOW-1:0]   to_cnt;

  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] rr_next;
  logic [7:0]       m_bytes [NUM_REQ];

  // Split the flat data bus into one byte per requester
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      m_bytes[i] = m_data[8*i +: 8];
    end
  end

  // First requesting port at or above rr_ptr, wrapping; scanned from the far
  // end so the nearest candidate is the last one written
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % int'(NUM_REQ));
      if (m_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Pointer rotates to the port just after the owner that is releasing
  always_comb begin
    rr_next = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
  end

  // Arbitration FSM with all link outputs registered
  always_ff @(posedge clk_sig or posedge rst_n) begin
    if (rst_n) begin
      state       <= IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      to_cnt      <= '0;
      grant       <= '0;
      m_ack       <= '0;
      s_req       <= 1'b0;
      s_data      <= 8'h00;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_found) begin
            grant <= GRANT_LSB << win_idx;
            owner <= win_idx;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (m_req[owner]) begin
            s_req  <= 1'b1;
            s_data <= m_bytes[owner];
            to_cnt <= '0;
            state  <= WAIT_ACK;
          end else begin
            // owner has nothing more to send: end the burst early
            state <= RELEASE;
          end
        end
        WAIT_ACK: begin
          // an ack arriving on the last allowed cycle still counts
          if (s_ack) begin
            s_req        <= 1'b0;
            m_ack[owner] <= 1'b1;
            state        <= WAIT_LOW;
          end else if (to_cnt == TOW'(TIMEOUT - 1)) begin
            s_req       <= 1'b0;
            timeout_err <= 1'b1;
            state       <= RELEASE;
          end else begin
            to_cnt <= to_cnt + TOW'(1);
          end
        end
        WAIT_LOW: begin
          if (!s_ack && !m_req[owner]) begin
            m_ack <= '0;
            if (beat_cnt == BCW'(BURST_LEN - 1)) begin
              state <= RELEASE;
            end else begin
              beat_cnt <= beat_cnt + BCW'(1);
              state    <= GRANT;
            end
          end
        end
        RELEASE: begin
          grant    <= '0;
          beat_cnt <= '0;
          rr_ptr   <= rr_next;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
